// File: rtl/bfm_apb_gpio_out_slave.sv
// APB3 GPIO output slave with DATA/SET/CLR/TGL/INFO registers and fixed wait states.
// Optional macro APB_GPIO_OUT_SLVERR_EN enables PSLVERR for unmapped, misaligned and INFO-write accesses.
module bfm_apb_gpio_out_slave #(
    parameter int          NUM_OUT     = 32,
    parameter logic [31:0] RESET_VAL   = 32'h0,
    parameter int          WAIT_STATES = 0,
    parameter int          TPD         = 1
) (
    input  logic               HCLK,
    input  logic               HRESETN,
    input  logic               PSEL,
    input  logic [7:0]         PADDR,
    input  logic               PWRITE,
    input  logic               PENABLE,
    input  logic [31:0]        PWDATA,
    output logic [31:0]        PRDATA,
    output logic               PREADY,
    output logic               PSLVERR,
    output logic [NUM_OUT-1:0] GPIO_OUT
);

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [31:0] INFO_VAL  = {16'h0, 8'(WAIT_STATES), 8'(NUM_OUT)};

    // Outputs are zero-delay in RTL; TPD only matters to timing-annotated wrappers.
    if (NUM_OUT < 1 || NUM_OUT > 32 || WAIT_STATES < 0 || WAIT_STATES > 15 || TPD < 0) begin : g_param_out_of_range
    end

    state_t             state_reg, state_next;
    logic [3:0]         wcnt_reg, wcnt_next;
    logic [NUM_OUT-1:0] gpio_reg, gpio_next;

    logic               sel_data, sel_set, sel_clr, sel_tgl, sel_info;
    logic               pready_int, slverr_int;
    logic [NUM_OUT-1:0] wdata;
    logic [31:0]        gpio_ext, rdata_mux;

    assign sel_data = (PADDR == 8'h00);
    assign sel_set  = (PADDR == 8'h04);
    assign sel_clr  = (PADDR == 8'h08);
    assign sel_tgl  = (PADDR == 8'h0C);
    assign sel_info = (PADDR == 8'h10);
    assign wdata    = PWDATA[NUM_OUT-1:0];

    assign pready_int = (state_reg == ST_ACCESS) && PSEL && PENABLE && (wcnt_reg == 4'd0);

`ifdef APB_GPIO_OUT_SLVERR_EN
    assign slverr_int = pready_int &&
                        ((PADDR > 8'h10) || (PADDR[1:0] != 2'b00) || (PWRITE && sel_info));
`else
    assign slverr_int = 1'b0;
`endif

    always_comb begin
        gpio_ext = '0;
        gpio_ext[NUM_OUT-1:0] = gpio_reg;
    end

    always_comb begin
        rdata_mux = '0;
        if (sel_data)
            rdata_mux = gpio_ext;
        else if (sel_info)
            rdata_mux = INFO_VAL;
    end

    // Misaligned/unmapped offsets never match a write decode, so they drop naturally.
    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        gpio_next  = gpio_reg;
        case (state_reg)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_next = ST_ACCESS;
                    wcnt_next  = WAIT_INIT;
                end
            end
            ST_ACCESS: begin
                if (!PSEL) begin
                    state_next = ST_IDLE;
                end else if (PENABLE) begin
                    if (wcnt_reg != 4'd0) begin
                        wcnt_next = wcnt_reg - 4'd1;
                    end else begin
                        state_next = ST_IDLE;
                        if (PWRITE) begin
                            if (sel_data)
                                gpio_next = wdata;
                            else if (sel_set)
                                gpio_next = gpio_reg | wdata;
                            else if (sel_clr)
                                gpio_next = gpio_reg & ~wdata;
                            else if (sel_tgl)
                                gpio_next = gpio_reg ^ wdata;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state_reg <= ST_IDLE;
            wcnt_reg  <= 4'd0;
            gpio_reg  <= RESET_VAL[NUM_OUT-1:0];
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
            gpio_reg  <= gpio_next;
        end
    end

    assign PREADY   = pready_int;
    assign PSLVERR  = slverr_int;
    assign PRDATA   = (pready_int && !slverr_int) ? rdata_mux : 32'h0;
    assign GPIO_OUT = gpio_reg;

endmodule

// File: tb/tb_bfm_apb_gpio_out_slave.sv
// Directed bench for bfm_apb_gpio_out_slave: three instances share the APB bus, each with its own PSEL.
// Table-driven transfers plus hand sequences for abort, protocol error and mid-transfer reset.
module tb_bfm_apb_gpio_out_slave;

`ifdef APB_GPIO_OUT_SLVERR_EN
    localparam bit E = 1'b1;
`else
    localparam bit E = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETN;
    logic [2:0]  psel_v;
    logic [7:0]  PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic [31:0] PWDATA;

    logic [31:0] prdata_a, prdata_b, prdata_c;
    logic        pready_a, pready_b, pready_c;
    logic        pslverr_a, pslverr_b, pslverr_c;
    logic [31:0] gpio_a, gpio_b;
    logic [7:0]  gpio_c;

    int tests = 0;
    int fails = 0;
    int cur   = 0;

    always #5 HCLK = ~HCLK;

    // A: 32 bits, no waits.  B: 32 bits, 3 waits.  C: 8 bits, 2 waits.
    bfm_apb_gpio_out_slave #(.NUM_OUT(32), .RESET_VAL(32'hA5), .WAIT_STATES(0), .TPD(1)) dut_a (
        .HCLK(HCLK), .HRESETN(HRESETN), .PSEL(psel_v[0]), .PADDR(PADDR), .PWRITE(PWRITE),
        .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(prdata_a), .PREADY(pready_a),
        .PSLVERR(pslverr_a), .GPIO_OUT(gpio_a));

    bfm_apb_gpio_out_slave #(.NUM_OUT(32), .RESET_VAL(32'h0), .WAIT_STATES(3), .TPD(1)) dut_b (
        .HCLK(HCLK), .HRESETN(HRESETN), .PSEL(psel_v[1]), .PADDR(PADDR), .PWRITE(PWRITE),
        .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(prdata_b), .PREADY(pready_b),
        .PSLVERR(pslverr_b), .GPIO_OUT(gpio_b));

    bfm_apb_gpio_out_slave #(.NUM_OUT(8), .RESET_VAL(32'h1234), .WAIT_STATES(2), .TPD(1)) dut_c (
        .HCLK(HCLK), .HRESETN(HRESETN), .PSEL(psel_v[2]), .PADDR(PADDR), .PWRITE(PWRITE),
        .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(prdata_c), .PREADY(pready_c),
        .PSLVERR(pslverr_c), .GPIO_OUT(gpio_c));

    logic        cur_pready, cur_pslverr;
    logic [31:0] cur_prdata, cur_gpio;

    always_comb begin
        cur_pready  = pready_a;
        cur_pslverr = pslverr_a;
        cur_prdata  = prdata_a;
        cur_gpio    = gpio_a;
        case (cur)
            1: begin cur_pready = pready_b; cur_pslverr = pslverr_b; cur_prdata = prdata_b; cur_gpio = gpio_b; end
            2: begin cur_pready = pready_c; cur_pslverr = pslverr_c; cur_prdata = prdata_c; cur_gpio = {24'h0, gpio_c}; end
            default: ;
        endcase
    end

    typedef struct {
        int          sel;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_waits;
        logic [31:0] exp_gpio;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after completion,
    // so consecutive calls produce back-to-back transfers.
    task automatic xfer(input int sel, input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int waits);
        bit done;
        cur     = sel;
        psel_v  = 3'b000;
        psel_v[sel] = 1'b1;
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = wdata;
        PENABLE = 1'b0;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        waits = 0;
        done  = 1'b0;
        rdata = '0;
        err   = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge HCLK);
            if (cur_pready) begin
                rdata = cur_prdata;
                err   = cur_pslverr;
                done  = 1'b1;
            end else begin
                waits++;
            end
            @(posedge HCLK); #1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL xfer_timeout: sel %0d addr %h got no PREADY within 40 cycles, expected PREADY", sel, addr);
        end
        psel_v  = 3'b000;
        PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          wt;

        vecs[0]  = '{0, 1'b1, 8'h00, 32'h0000_00F0, 32'h0,         1'b0, 0, 32'h0000_00F0};
        vecs[1]  = '{0, 1'b0, 8'h00, 32'h0,         32'h0000_00F0, 1'b0, 0, 32'h0000_00F0};
        vecs[2]  = '{0, 1'b1, 8'h04, 32'h0000_000F, 32'h0,         1'b0, 0, 32'h0000_00FF};
        vecs[3]  = '{0, 1'b1, 8'h08, 32'h0000_0030, 32'h0,         1'b0, 0, 32'h0000_00CF};
        vecs[4]  = '{0, 1'b1, 8'h0C, 32'h0000_00FF, 32'h0,         1'b0, 0, 32'h0000_0030};
        vecs[5]  = '{0, 1'b0, 8'h04, 32'h0,         32'h0,         1'b0, 0, 32'h0000_0030};
        vecs[6]  = '{0, 1'b0, 8'h10, 32'h0,         32'h0000_0020, 1'b0, 0, 32'h0000_0030};
        vecs[7]  = '{0, 1'b1, 8'h14, 32'h0000_0001, 32'h0,         E,    0, 32'h0000_0030};
        vecs[8]  = '{0, 1'b0, 8'h02, 32'h0,         32'h0,         E,    0, 32'h0000_0030};
        vecs[9]  = '{0, 1'b1, 8'h10, 32'h0000_FFFF, 32'h0,         E,    0, 32'h0000_0030};
        vecs[10] = '{0, 1'b0, 8'h00, 32'h0,         32'h0000_0030, 1'b0, 0, 32'h0000_0030};
        vecs[11] = '{1, 1'b0, 8'h10, 32'h0,         32'h0000_0320, 1'b0, 3, 32'h0000_0000};
        vecs[12] = '{1, 1'b1, 8'h00, 32'hDEAD_BEEF, 32'h0,         1'b0, 3, 32'hDEAD_BEEF};
        vecs[13] = '{1, 1'b0, 8'h00, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 32'hDEAD_BEEF};
        vecs[14] = '{2, 1'b1, 8'h00, 32'hFFFF_FF5A, 32'h0,         1'b0, 2, 32'h0000_005A};
        vecs[15] = '{2, 1'b0, 8'h00, 32'h0,         32'h0000_005A, 1'b0, 2, 32'h0000_005A};
        vecs[16] = '{2, 1'b1, 8'h04, 32'h0000_0100, 32'h0,         1'b0, 2, 32'h0000_005A};
        vecs[17] = '{2, 1'b1, 8'h0C, 32'h0000_000F, 32'h0,         1'b0, 2, 32'h0000_0055};
        vecs[18] = '{2, 1'b0, 8'h10, 32'h0,         32'h0000_0208, 1'b0, 2, 32'h0000_0055};

        HRESETN = 1'b0;
        psel_v  = 3'b000;
        PADDR   = 8'h00;
        PWRITE  = 1'b0;
        PENABLE = 1'b0;
        PWDATA  = 32'h0;
        repeat (3) @(posedge HCLK);
        #1 HRESETN = 1'b1;

        @(negedge HCLK);
        check("reset_gpio_a", gpio_a, 32'hA5);
        check("reset_gpio_b", gpio_b, 32'h0);
        check("reset_gpio_c", {24'h0, gpio_c}, 32'h34);
        check("reset_pready", {29'h0, pready_a, pready_b, pready_c}, 32'h0);
        check("reset_pslverr", {29'h0, pslverr_a, pslverr_b, pslverr_c}, 32'h0);
        check("reset_prdata", prdata_a | prdata_b | prdata_c, 32'h0);
        @(posedge HCLK); #1;

        for (int i = 0; i < NV; i++) begin
            xfer(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, wt);
            if (!vecs[i].wr)
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_pslverr", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
            check($sformatf("vec%0d_waits", i), wt, vecs[i].exp_waits);
            check($sformatf("vec%0d_gpio", i), cur_gpio, vecs[i].exp_gpio);
            $display("[TB] vec %0d sel=%0d %s addr=%h wdata=%h rdata=%h err=%0d waits=%0d gpio=%h",
                     i, vecs[i].sel, vecs[i].wr ? "WR" : "RD", vecs[i].addr, vecs[i].wdata, rd, er, wt, cur_gpio);
        end

        // Abort: PSEL drops after setup, before the access phase.
        cur = 0;
        psel_v = 3'b001; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h11; PENABLE = 1'b0;
        @(posedge HCLK); #1;
        psel_v = 3'b000;
        @(negedge HCLK);
        check("abort_pready", {31'h0, pready_a}, 32'h0);
        @(posedge HCLK); #1;
        check("abort_gpio", gpio_a, 32'h30);
        $display("[TB] abort sequence gpio_a=%h", gpio_a);
        xfer(0, 1'b0, 8'h00, 32'h0, rd, er, wt);
        check("abort_recover_rdata", rd, 32'h30);
        check("abort_recover_waits", wt, 0);
        $display("[TB] post-abort read rdata=%h waits=%0d", rd, wt);

        // Protocol error: PSEL and PENABLE together from IDLE must be ignored.
        psel_v = 3'b001; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h99; PENABLE = 1'b1;
        @(negedge HCLK);
        check("proto_pready_1", {31'h0, pready_a}, 32'h0);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        check("proto_pready_2", {31'h0, pready_a}, 32'h0);
        check("proto_prdata", prdata_a, 32'h0);
        @(posedge HCLK); #1;
        psel_v = 3'b000; PENABLE = 1'b0;
        check("proto_gpio", gpio_a, 32'h30);
        $display("[TB] protocol-error sequence gpio_a=%h", gpio_a);

        // Reset during the access phase of a write to C (2 wait states).
        cur = 2;
        psel_v = 3'b100; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h1; PENABLE = 1'b0;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        @(negedge HCLK);
        check("rst_mid_pready", {31'h0, pready_c}, 32'h0);
        @(posedge HCLK); #1;
        HRESETN = 1'b0;
        @(posedge HCLK); #1;
        HRESETN = 1'b1;
        psel_v = 3'b000; PENABLE = 1'b0;
        check("rst_mid_gpio_c", {24'h0, gpio_c}, 32'h34);
        check("rst_mid_gpio_a", gpio_a, 32'hA5);
        @(negedge HCLK);
        check("rst_mid_idle_pready", {31'h0, pready_c}, 32'h0);
        @(posedge HCLK); #1;
        $display("[TB] mid-access reset gpio_c=%h gpio_a=%h", gpio_c, gpio_a);
        xfer(2, 1'b1, 8'h00, 32'h77, rd, er, wt);
        check("rst_after_waits", wt, 2);
        check("rst_after_gpio", {24'h0, gpio_c}, 32'h77);
        check("rst_after_pslverr", {31'h0, er}, 32'h0);
        $display("[TB] post-reset write gpio_c=%h waits=%0d", gpio_c, wt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
